// File: rtl/sdram_wb_bridge.sv
// sdram_wb_bridge: Wishbone-style 16-bit port to SDRAM controller req/ack bridge
// with controller reset sequencing, init-done sync, byte masks and a timeout watchdog.
module sdram_wb_bridge #(
   parameter int RST_DELAY = 4,
   parameter int TIMEOUT   = 1023
) (
   input  logic        clk_p,
   input  logic        sdram_reset,
   input  logic        wb_stb,
   input  logic        wb_we,
   input  logic [1:0]  wb_sel,
   input  logic [20:0] wb_adr,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   output logic        wb_ack,
   output logic        ctl_rst_n,
   input  logic        ctl_init_done,
   output logic        ctl_wr_req,
   output logic        ctl_rd_req,
   input  logic        ctl_wr_ack,
   input  logic        ctl_rd_ack,
   output logic [21:0] ctl_addr,
   output logic [15:0] ctl_wdata,
   input  logic [15:0] ctl_rdata,
   output logic        dqm_h,
   output logic        dqm_l,
   output logic        ready,
   output logic        busy,
   output logic        timeout_err
);
   typedef enum logic [1:0] {IDLE, REQ, ACK, DRAIN} state_t;
   state_t state, state_nx;
   logic [3:0]  rst_cnt;
   logic        sync1;
   logic [9:0]  tcnt;
   logic [20:0] adr_q;
   logic        we_q, ack_flag;
   logic        start, hit, tmo, done;
   always_ff @(posedge clk_p or posedge sdram_reset)
      if (sdram_reset) begin
         rst_cnt   <= '0;
         ctl_rst_n <= 1'b0;
      end else if (!ctl_rst_n) begin
         rst_cnt   <= rst_cnt + 4'd1;
         ctl_rst_n <= rst_cnt == 4'(RST_DELAY - 1);
      end
   always_ff @(posedge clk_p or posedge sdram_reset)
      if (sdram_reset) begin
         sync1 <= 1'b0;
         ready <= 1'b0;
      end else begin
         sync1 <= ctl_init_done;
         ready <= sync1;
      end
   always_comb begin
      start    = state == IDLE && wb_stb && ready;
      hit      = state == REQ && (we_q ? ctl_wr_ack : ctl_rd_ack);
      tmo      = state == REQ && !hit && tcnt == 10'(TIMEOUT - 1);
      done     = hit || tmo;
      state_nx = state;
      if (start)
         state_nx = (wb_we && wb_sel == 2'b00) ? ACK : REQ;
      else if (done)
         state_nx = wb_stb ? ACK : DRAIN;
      else if ((state == ACK && !wb_stb) || state == DRAIN)
         state_nx = IDLE;
   end
   always_ff @(posedge clk_p or posedge sdram_reset)
      if (sdram_reset) state <= IDLE;
      else             state <= state_nx;
   always_ff @(posedge clk_p or posedge sdram_reset)
      if (sdram_reset) begin
         adr_q       <= '0;
         we_q        <= 1'b0;
         ctl_wdata   <= '0;
         dqm_h       <= 1'b0;
         dqm_l       <= 1'b0;
         tcnt        <= '0;
         ctl_wr_req  <= 1'b0;
         ctl_rd_req  <= 1'b0;
         wb_dat_o    <= '0;
         timeout_err <= 1'b0;
         ack_flag    <= 1'b0;
      end else begin
         if (start) begin
            adr_q      <= wb_adr;
            we_q       <= wb_we;
            ctl_wdata  <= wb_dat_i;
            dqm_h      <= wb_we & ~wb_sel[1];
            dqm_l      <= wb_we & ~wb_sel[0];
            tcnt       <= '0;
            ctl_wr_req <= wb_we && wb_sel != 2'b00;
            ctl_rd_req <= !wb_we;
         end else if (state == REQ)
            tcnt <= tcnt + 10'd1;
         if (done) begin
            ctl_wr_req <= 1'b0;
            ctl_rd_req <= 1'b0;
            if (!we_q) wb_dat_o <= hit ? ctl_rdata : 16'hFFFF;
            if (tmo) timeout_err <= 1'b1;
         end
         // the empty-select write path reaches ACK first and raises the flag one edge later
         ack_flag <= wb_stb && (done || state == ACK);
      end
   assign ctl_addr = {1'b0, adr_q};
   assign wb_ack   = ack_flag & wb_stb;
   assign busy     = state != IDLE;
endmodule

// File: tb/tb_sdram_wb_bridge.sv
// tb_sdram_wb_bridge: directed checks of sdram_wb_bridge with RST_DELAY=4, TIMEOUT=8.
module tb_sdram_wb_bridge;
   logic        clk_p = 1'b0, sdram_reset = 1'b1;
   logic        wb_stb = 0, wb_we = 0;
   logic [1:0]  wb_sel = 0;
   logic [20:0] wb_adr = 0;
   logic [15:0] wb_dat_i = 0, wb_dat_o;
   logic        wb_ack, ctl_rst_n, ctl_init_done = 0, ctl_wr_req, ctl_rd_req;
   logic        ctl_wr_ack = 0, ctl_rd_ack = 0;
   logic [21:0] ctl_addr;
   logic [15:0] ctl_wdata, ctl_rdata = 0;
   logic        dqm_h, dqm_l, ready, busy, timeout_err;
   int n_chk = 0, n_fail = 0;

   sdram_wb_bridge #(.RST_DELAY(4), .TIMEOUT(8)) dut (
      .clk_p(clk_p), .sdram_reset(sdram_reset), .wb_stb(wb_stb), .wb_we(wb_we),
      .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_ack(wb_ack), .ctl_rst_n(ctl_rst_n), .ctl_init_done(ctl_init_done),
      .ctl_wr_req(ctl_wr_req), .ctl_rd_req(ctl_rd_req), .ctl_wr_ack(ctl_wr_ack),
      .ctl_rd_ack(ctl_rd_ack), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
      .ctl_rdata(ctl_rdata), .dqm_h(dqm_h), .dqm_l(dqm_l), .ready(ready),
      .busy(busy), .timeout_err(timeout_err));

   always #5 clk_p = ~clk_p;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_p);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      tick(5);
      chk("rst_ctl_rst_n", 32'(ctl_rst_n), 0);
      chk("rst_ready", 32'(ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_addr", 32'(ctl_addr), 0);
      chk("rst_dat_o", 32'(wb_dat_o), 0);
      sdram_reset = 0;
      tick(3);
      chk("rst_n_edge3", 32'(ctl_rst_n), 0);
      tick();
      chk("rst_n_edge4", 32'(ctl_rst_n), 1);
      // strobe pending before ready
      wb_stb = 1; wb_we = 0; wb_sel = 2'b11; wb_adr = 21'h12345;
      tick(3);
      chk("noready_rd_req", 32'(ctl_rd_req), 0);
      chk("noready_busy", 32'(busy), 0);
      ctl_init_done = 1;
      tick();
      chk("ready_edge1", 32'(ready), 0);
      tick();
      chk("ready_edge2", 32'(ready), 1);
      tick();
      chk("rd_req", 32'(ctl_rd_req), 1);
      chk("rd_addr", 32'(ctl_addr), 32'h012345);
      chk("rd_dqm", {30'd0, dqm_h, dqm_l}, 0);
      wb_adr = 21'h0;
      tick(2);
      chk("rd_req_held", 32'(ctl_rd_req), 1);
      chk("rd_addr_held", 32'(ctl_addr), 32'h012345);
      ctl_rd_ack = 1; ctl_rdata = 16'hBEEF;
      tick();
      ctl_rd_ack = 0; ctl_rdata = 0;
      chk("rd_ack", 32'(wb_ack), 1);
      chk("rd_dat", 32'(wb_dat_o), 32'hBEEF);
      chk("rd_req_drop", 32'(ctl_rd_req), 0);
      wb_stb = 0;
      #1;
      chk("rd_ack_drop", 32'(wb_ack), 0);
      tick();
      chk("rd_idle", 32'(busy), 0);
      // byte write, high byte only
      wb_stb = 1; wb_we = 1; wb_sel = 2'b10; wb_dat_i = 16'hA55A; wb_adr = 21'h00100;
      tick();
      chk("wr_req", 32'(ctl_wr_req), 1);
      chk("wr_dqm", {30'd0, dqm_h, dqm_l}, 32'b01);
      chk("wr_wdata", 32'(ctl_wdata), 32'hA55A);
      wb_dat_i = 0;
      ctl_rd_ack = 1;
      tick();
      ctl_rd_ack = 0;
      chk("wr_ignore_rd_ack", 32'(ctl_wr_req), 1);
      chk("wr_wdata_held", 32'(ctl_wdata), 32'hA55A);
      chk("wr_no_ack", 32'(wb_ack), 0);
      ctl_wr_ack = 1;
      tick();
      ctl_wr_ack = 0;
      chk("wr_ack", 32'(wb_ack), 1);
      chk("wr_req_drop", 32'(ctl_wr_req), 0);
      wb_stb = 0;
      tick();
      // empty-select write
      wb_stb = 1; wb_we = 1; wb_sel = 2'b00;
      tick();
      chk("sel0_ack_e1", 32'(wb_ack), 0);
      chk("sel0_busy", 32'(busy), 1);
      chk("sel0_no_req_e1", 32'(ctl_wr_req), 0);
      tick();
      chk("sel0_ack_e2", 32'(wb_ack), 1);
      chk("sel0_no_req_e2", 32'(ctl_wr_req), 0);
      wb_stb = 0;
      tick();
      chk("sel0_idle", 32'(busy), 0);
      // read that is never acked
      wb_stb = 1; wb_we = 0; wb_sel = 2'b11; wb_adr = 21'h5;
      tick(8);
      chk("tmo_req_before", 32'(ctl_rd_req), 1);
      chk("tmo_err_before", 32'(timeout_err), 0);
      tick();
      chk("tmo_req_drop", 32'(ctl_rd_req), 0);
      chk("tmo_dat", 32'(wb_dat_o), 32'hFFFF);
      chk("tmo_ack", 32'(wb_ack), 1);
      chk("tmo_err", 32'(timeout_err), 1);
      wb_stb = 0;
      tick();
      wb_stb = 1; wb_we = 1; wb_sel = 2'b11; wb_dat_i = 16'h1234;
      tick();
      chk("good_dqm", {30'd0, dqm_h, dqm_l}, 0);
      ctl_wr_ack = 1;
      tick();
      ctl_wr_ack = 0;
      chk("good_ack", 32'(wb_ack), 1);
      chk("tmo_err_sticky", 32'(timeout_err), 1);
      wb_stb = 0;
      tick();
      // master withdraws during REQ
      wb_stb = 1; wb_we = 0; wb_adr = 21'h77;
      tick();
      chk("drain_req", 32'(ctl_rd_req), 1);
      wb_stb = 0;
      tick();
      ctl_rd_ack = 1; ctl_rdata = 16'h7777;
      tick();
      ctl_rd_ack = 0; ctl_rdata = 0;
      chk("drain_no_ack", 32'(wb_ack), 0);
      chk("drain_busy", 32'(busy), 1);
      chk("drain_dat", 32'(wb_dat_o), 32'h7777);
      tick();
      chk("drain_idle", 32'(busy), 0);
      chk("drain_no_ack2", 32'(wb_ack), 0);
      wb_stb = 1; wb_adr = 21'h1FFFFF;
      tick();
      chk("post_addr", 32'(ctl_addr), 32'h1FFFFF);
      ctl_rd_ack = 1; ctl_rdata = 16'h0F0F;
      tick();
      ctl_rd_ack = 0; ctl_rdata = 0;
      chk("post_ack", 32'(wb_ack), 1);
      chk("post_dat", 32'(wb_dat_o), 32'h0F0F);
      tick();
      chk("post_ack_hold", 32'(wb_ack), 1);
      wb_stb = 0;
      tick();
      // async reset in the middle of a request
      wb_stb = 1; wb_adr = 21'h42;
      tick();
      chk("arst_pre_req", 32'(ctl_rd_req), 1);
      #2 sdram_reset = 1;
      #1;
      chk("arst_req", 32'(ctl_rd_req), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_err", 32'(timeout_err), 0);
      chk("arst_rst_n", 32'(ctl_rst_n), 0);
      chk("arst_ready", 32'(ready), 0);
      chk("arst_dat", 32'(wb_dat_o), 0);
      chk("arst_addr", 32'(ctl_addr), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
